divb: RTL and testbench
=======================

DIVB -- requirements
Module: divb

Interface
REQ-001 Parameter NUM_W, default 18, SHALL set the dividend and quotient width in bits.
REQ-002 Parameter DEN_W, default 9, SHALL set the divisor and remainder width in bits; NUM_W >= DEN_W.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 enable  input  1  SHALL be the clock enable; when low, all state and outputs SHALL hold.
REQ-006 start  input  1  SHALL request a division; it is sampled only in IDLE with enable high.
REQ-007 a  input  NUM_W  SHALL be the unsigned dividend, captured on an accepted start.
REQ-008 b  input  DEN_W  SHALL be the unsigned divisor, captured on an accepted start.
REQ-009 busy  output  1  SHALL be high while a division is in progress (CALC state).
REQ-010 done  output  1  SHALL pulse high for exactly one enabled cycle when q and r become valid.
REQ-011 q  output  NUM_W  SHALL be the quotient, held until the next accepted start.
REQ-012 r  output  DEN_W  SHALL be the remainder, held until the next accepted start.
REQ-013 div_by_zero  output  1  SHALL flag that the last completed division had b == 0; it is held with q and r.

Function
REQ-014 The FSM SHALL have three states:
- IDLE: go to CALC on start with b != 0; go to DONE on start with b == 0.
- CALC: go to DONE after NUM_W enabled cycles.
- DONE: return to IDLE after one enabled cycle.
REQ-015 In CALC the block SHALL run unsigned restoring division, one quotient bit per enabled cycle, MSB first.
- Each step: shift the remainder register left by 1 and bring in the next dividend bit.
- If the partial remainder >= divisor, subtract the divisor and set the quotient bit to 1; otherwise the bit is 0.
REQ-016 The partial-remainder register SHALL be DEN_W+1 bits wide so the compare never overflows; r SHALL take its low DEN_W bits.
REQ-017 For b != 0, done SHALL rise NUM_W+1 enabled cycles after the enabled edge that accepted start (19 cycles at default widths).
REQ-018 For b == 0, the block SHALL bypass CALC and set:
- q = all ones
- r = a[DEN_W-1:0]
- div_by_zero = 1
- done one enabled cycle after the accepted start.
REQ-019 q, r and div_by_zero SHALL update together, on the edge that enters DONE.
REQ-020 Results SHALL satisfy a == q*b + r with r < b whenever b != 0.
REQ-021 start SHALL be ignored while the FSM is in CALC or DONE; no queueing.
REQ-022 A start asserted in the same cycle done is high SHALL be ignored; it is accepted only from the next IDLE cycle.
REQ-023 Deasserting enable mid-CALC SHALL stall the iteration with no bit lost; the final result SHALL be unchanged, only delayed.
REQ-024 enable SHALL be used as a synchronous clock enable, never ANDed into the clock.

Reset
REQ-025 On reset assertion, independent of clk, the block SHALL:
- enter IDLE
- clear busy, done, q, r, div_by_zero and all internal registers to 0.
REQ-026 A reset during CALC SHALL abort the division with no done pulse; the first accepted start after release SHALL run normally.

Structure
REQ-027 Package divb_pkg SHALL hold the FSM state enum (IDLE, CALC, DONE) and the default NUM_W/DEN_W constants.
REQ-028 A combinational sub-module divb_step (one shift-compare-subtract step) is natural; the FSM and iteration counter SHALL remain in divb.
REQ-029 The iteration counter SHALL be $clog2(NUM_W+1) bits wide.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- a=100, b=7, enable=1 -> q=14, r=2, div_by_zero=0; done exactly 19 cycles after start; busy high for 18 cycles.
- a=0x3FFFF, b=0x1FF -> q=513, r=0; a=12, b=13 -> q=0, r=12.
- a=5, b=0 -> done 1 cycle after start; q=0x3FFFF, r=5, div_by_zero=1; busy never high.
- a=100, b=7 with enable low for 5 cycles mid-CALC -> done at cycle 24; q=14, r=2.
- Second start (a=9, b=3) pulsed during CALC of a=100, b=7 -> ignored; q=14, r=2; only one done pulse.
- reset asserted at cycle 10 of CALC -> all outputs 0 immediately, no done; next start a=50, b=5 -> q=10, r=0.

Source files
------------

// File: rtl/divb_pkg.sv
// divb_pkg: shared definitions for the divb restoring divider.
//   - NumWDef / DenWDef: default dividend/quotient and divisor/remainder widths.
//   - state_e: FSM state encoding (idle, iterating, result-valid).
package divb_pkg;

   localparam int unsigned NumWDef = 18;
   localparam int unsigned DenWDef = 9;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StCalc = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/divb_if.sv
// divb_if: request/result bundle between a requester (master) and the divider (slave).
//   enable      : clock enable (master -> slave)
//   start, a, b : division request, dividend and divisor (master -> slave)
//   busy, done  : iteration in progress / one-cycle result-valid pulse (slave -> master)
//   q, r        : quotient and remainder (slave -> master)
//   div_by_zero : last completed division had b == 0 (slave -> master)
interface divb_if #(
   parameter int unsigned NUM_W = 18,
   parameter int unsigned DEN_W = 9
);
   logic             enable;
   logic             start;
   logic [NUM_W-1:0] a;
   logic [DEN_W-1:0] b;
   logic             busy;
   logic             done;
   logic [NUM_W-1:0] q;
   logic [DEN_W-1:0] r;
   logic             div_by_zero;

   modport master (
      output enable, start, a, b,
      input  busy, done, q, r, div_by_zero
   );

   modport slave (
      input  enable, start, a, b,
      output busy, done, q, r, div_by_zero
   );
endinterface

// File: rtl/divb_step.sv
// divb_step: one combinational restoring-division step.
//   rem_i  : current partial remainder (DEN_W+1 bits, always < divisor)
//   bit_i  : next dividend bit shifted in
//   div_i  : divisor
//   rem_o  : next partial remainder
//   qbit_o : quotient bit produced by this step
module divb_step #(
   parameter int unsigned DEN_W = 9
) (
   input  logic [DEN_W:0]   rem_i,
   input  logic             bit_i,
   input  logic [DEN_W-1:0] div_i,
   output logic [DEN_W:0]   rem_o,
   output logic             qbit_o
);
   logic [DEN_W:0] shifted;
   logic           unused_rem_msb;

   // The incoming remainder is always below the divisor, so its MSB is zero and
   // the shifted value still fits in DEN_W+1 bits.
   assign unused_rem_msb = rem_i[DEN_W];
   assign shifted        = {rem_i[DEN_W-1:0], bit_i};

   always_comb begin
      rem_o  = shifted;
      qbit_o = 1'b0;
      if (shifted >= {1'b0, div_i}) begin
         rem_o  = shifted - {1'b0, div_i};
         qbit_o = 1'b1;
      end
   end
endmodule

// File: rtl/divb.sv
// divb: sequential unsigned restoring divider, one quotient bit per enabled cycle.
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : divb_if slave modport (enable, start, a, b in; busy, done, q, r, div_by_zero out)
// A division by zero skips iteration and returns q = all ones, r = a[DEN_W-1:0].
module divb
   import divb_pkg::*;
#(
   parameter int unsigned NUM_W = NumWDef,
   parameter int unsigned DEN_W = DenWDef
) (
   input logic   clk,
   input logic   reset,
   divb_if.slave bus
);
   localparam int unsigned CntW = $clog2(NUM_W + 1);

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   // Dividend bits shift out of the top while quotient bits shift in at the bottom.
   logic [NUM_W-1:0] dvd_q, dvd_d;
   logic [DEN_W-1:0] div_q, div_d;
   logic [DEN_W:0]   rem_q, rem_d;
   logic [NUM_W-1:0] q_q, q_d;
   logic [DEN_W-1:0] r_q, r_d;
   logic             dbz_q, dbz_d;

   logic [DEN_W:0]   rem_step;
   logic             qbit;
   logic             last_step;

   divb_step #(
      .DEN_W (DEN_W)
   ) u_step (
      .rem_i  (rem_q),
      .bit_i  (dvd_q[NUM_W-1]),
      .div_i  (div_q),
      .rem_o  (rem_step),
      .qbit_o (qbit)
   );

   assign last_step = (cnt_q == CntW'(NUM_W - 1));

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else if (bus.enable) begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d = (bus.b == '0) ? StDone : StCalc;
            end
         end
         StCalc: begin
            if (last_step) begin
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs
   always_comb begin
      bus.busy        = (state_q == StCalc);
      bus.done        = (state_q == StDone);
      bus.q           = q_q;
      bus.r           = r_q;
      bus.div_by_zero = dbz_q;
   end

   // Datapath next-state
   always_comb begin
      cnt_d = cnt_q;
      dvd_d = dvd_q;
      div_d = div_q;
      rem_d = rem_q;
      q_d   = q_q;
      r_d   = r_q;
      dbz_d = dbz_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               dvd_d = bus.a;
               div_d = bus.b;
               rem_d = '0;
               cnt_d = '0;
               if (bus.b == '0) begin
                  q_d   = '1;
                  r_d   = bus.a[DEN_W-1:0];
                  dbz_d = 1'b1;
               end
            end
         end
         StCalc: begin
            rem_d = rem_step;
            dvd_d = {dvd_q[NUM_W-2:0], qbit};
            cnt_d = cnt_q + 1'b1;
            if (last_step) begin
               cnt_d = '0;
               q_d   = {dvd_q[NUM_W-2:0], qbit};
               r_d   = rem_step[DEN_W-1:0];
               dbz_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
         dvd_q <= '0;
         div_q <= '0;
         rem_q <= '0;
         q_q   <= '0;
         r_q   <= '0;
         dbz_q <= 1'b0;
      end else if (bus.enable) begin
         cnt_q <= cnt_d;
         dvd_q <= dvd_d;
         div_q <= div_d;
         rem_q <= rem_d;
         q_q   <= q_d;
         r_q   <= r_d;
         dbz_q <= dbz_d;
      end
   end
endmodule

// File: tb/tb_divb.sv
// tb_divb: directed self-checking bench for divb at default widths (18/9).
module tb_divb;
   logic clk;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   divb_if #(.NUM_W(18), .DEN_W(9)) bus ();

   divb #(
      .NUM_W (18),
      .DEN_W (9)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Issues one start and watches a fixed 40-cycle window. Cycle 1 is the
   // sample just after the accepting edge. Optional enable stall and stray
   // start pulses (during CALC and during the done cycle).
   task automatic run(input logic [17:0] av, input logic [8:0] bv, input int stall_at,
                      input int stall_len, input bit poke,
                      output int lat, output int busy_n, output int done_n);
      bus.a     = av;
      bus.b     = bv;
      bus.start = 1'b1;
      lat       = -1;
      busy_n    = 0;
      done_n    = 0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         #1;
         bus.start = 1'b0;
         if (bus.done) begin
            done_n++;
            if (lat < 0) begin
               lat = c;
               if (poke) bus.start = 1'b1;
            end
         end
         if (bus.busy) busy_n++;
         if (stall_len > 0 && c == stall_at) bus.enable = 1'b0;
         if (stall_len > 0 && c == stall_at + stall_len) bus.enable = 1'b1;
         if (poke && c == 5) begin
            bus.a     = 18'd9;
            bus.b     = 9'd3;
            bus.start = 1'b1;
         end
      end
   endtask

   initial begin
      int lat, busy_n, done_n;
      reset      = 1'b0;
      bus.enable = 1'b0;
      bus.start  = 1'b0;
      bus.a      = '0;
      bus.b      = '0;
      #2 reset = 1'b1;
      #1;
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_q", 64'(bus.q), 64'd0);
      chk("rst_r", 64'(bus.r), 64'd0);
      chk("rst_dbz", 64'(bus.div_by_zero), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset      = 1'b0;
      bus.enable = 1'b1;
      @(negedge clk);

      // 100 / 7
      run(18'd100, 9'd7, 0, 0, 1'b0, lat, busy_n, done_n);
      chk("base_lat", 64'(lat), 64'd19);
      chk("base_busy", 64'(busy_n), 64'd18);
      chk("base_done_n", 64'(done_n), 64'd1);
      chk("base_q", 64'(bus.q), 64'd14);
      chk("base_r", 64'(bus.r), 64'd2);
      chk("base_dbz", 64'(bus.div_by_zero), 64'd0);

      // Max dividend / max divisor
      run(18'h3FFFF, 9'h1FF, 0, 0, 1'b0, lat, busy_n, done_n);
      chk("max_q", 64'(bus.q), 64'd513);
      chk("max_r", 64'(bus.r), 64'd0);

      // Dividend smaller than divisor
      run(18'd12, 9'd13, 0, 0, 1'b0, lat, busy_n, done_n);
      chk("small_q", 64'(bus.q), 64'd0);
      chk("small_r", 64'(bus.r), 64'd12);

      // Divide by zero
      run(18'd5, 9'd0, 0, 0, 1'b0, lat, busy_n, done_n);
      chk("dbz_lat", 64'(lat), 64'd1);
      chk("dbz_busy", 64'(busy_n), 64'd0);
      chk("dbz_done_n", 64'(done_n), 64'd1);
      chk("dbz_q", 64'(bus.q), 64'h3FFFF);
      chk("dbz_r", 64'(bus.r), 64'd5);
      chk("dbz_flag", 64'(bus.div_by_zero), 64'd1);

      // Enable low for 5 cycles mid-CALC
      run(18'd100, 9'd7, 5, 5, 1'b0, lat, busy_n, done_n);
      chk("stall_lat", 64'(lat), 64'd24);
      chk("stall_q", 64'(bus.q), 64'd14);
      chk("stall_r", 64'(bus.r), 64'd2);

      // Stray starts during CALC and during done
      run(18'd100, 9'd7, 0, 0, 1'b1, lat, busy_n, done_n);
      chk("poke_lat", 64'(lat), 64'd19);
      chk("poke_done_n", 64'(done_n), 64'd1);
      chk("poke_q", 64'(bus.q), 64'd14);
      chk("poke_r", 64'(bus.r), 64'd2);

      // Reset at cycle 10 of CALC
      bus.a     = 18'd100;
      bus.b     = 9'd7;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("abort_busy", 64'(bus.busy), 64'd0);
      chk("abort_done", 64'(bus.done), 64'd0);
      chk("abort_q", 64'(bus.q), 64'd0);
      chk("abort_r", 64'(bus.r), 64'd0);
      chk("abort_dbz", 64'(bus.div_by_zero), 64'd0);
      @(negedge clk);
      reset  = 1'b0;
      done_n = 0;
      for (int c = 0; c < 25; c++) begin
         @(posedge clk);
         #1;
         if (bus.done) done_n++;
      end
      chk("abort_no_done", 64'(done_n), 64'd0);

      run(18'd50, 9'd5, 0, 0, 1'b0, lat, busy_n, done_n);
      chk("after_lat", 64'(lat), 64'd19);
      chk("after_q", 64'(bus.q), 64'd10);
      chk("after_r", 64'(bus.r), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
